// File: rtl/ball_physics.sv
// ---------------------------------------------------------------------------
// ball_physics -- Pong square motion controller.
//
// Holds the square at screen centre while idle and during the serve delay,
// then moves it one pixel per axis per step. Steps are evaluated in the
// order left paddle hit, right paddle hit, miss, walls, then movement. A miss
// gives one MISS cycle, then the next serve heads toward the player who
// conceded, with the vertical direction toggled.
//
// CLK_HZ sets both the 1 ms tick and the step prescaler. It defaults to the
// 25.175 MHz pixel clock, so TICK = 25_175 cycles and
// PSC_LIMIT = 25_175_000 / BALL_SPEED.
//
// Ports:
//   clk_0        pixel clock
//   rst          asynchronous active-low reset
//   reset_game   synchronous restart: re-centre and re-serve
//   mode_choice  0 = idle, 1 = one player, 2 = two players
//   l_pdl_ypos   left paddle top y
//   r_pdl_ypos   right paddle top y
//   sq_xpos      square left x
//   sq_ypos      square top y
//   sq_xveldir   1 = moving right
//   sq_yveldir   1 = moving down
//   sq_missed    one-cycle pulse on a miss
//   miss_side    side of the last miss (0 = left, 1 = right)
//   paddle_hit   one-cycle pulse on a paddle bounce
// ---------------------------------------------------------------------------
module ball_physics #(
    parameter int H_VIDEO     = 640,
    parameter int V_VIDEO     = 480,
    parameter int SQ_SIZE     = 12,
    parameter int PDL_WIDTH   = 12,
    parameter int PDL_HEIGHT  = 96,
    parameter int L_PDL_X     = 24,
    parameter int R_PDL_X     = 604,
    parameter int BALL_SPEED  = 400,
    parameter int SERVE_DELAY = 1000,
    parameter int CLK_HZ      = 25_175_000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       reset_game,
    input  logic [1:0] mode_choice,
    input  logic [9:0] l_pdl_ypos,
    input  logic [9:0] r_pdl_ypos,
    output logic [9:0] sq_xpos,
    output logic [9:0] sq_ypos,
    output logic       sq_xveldir,
    output logic       sq_yveldir,
    output logic       sq_missed,
    output logic       miss_side,
    output logic       paddle_hit
);

    localparam int TICK_LIMIT = CLK_HZ / 1000;
    localparam int PSC_LIMIT  = CLK_HZ / BALL_SPEED;
    localparam int TICK_W     = $clog2(TICK_LIMIT + 1);
    localparam int DLY_W      = $clog2(SERVE_DELAY + 1);
    localparam int PSC_W      = $clog2(PSC_LIMIT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_LIMIT - 1);
    localparam logic [DLY_W-1:0]  DELAY_LAST = DLY_W'(SERVE_DELAY - 1);
    localparam logic [PSC_W-1:0]  PSC_LAST   = PSC_W'(PSC_LIMIT - 1);

    localparam logic [9:0]  X_CENTRE = 10'((H_VIDEO - SQ_SIZE) / 2);
    localparam logic [9:0]  Y_CENTRE = 10'((V_VIDEO - SQ_SIZE) / 2);
    localparam logic [10:0] SQ11     = 11'(SQ_SIZE);
    localparam logic [10:0] PH11     = 11'(PDL_HEIGHT);
    localparam logic [10:0] L_HIT_X  = 11'(L_PDL_X + PDL_WIDTH);
    localparam logic [10:0] R_PDL11  = 11'(R_PDL_X);
    localparam logic [10:0] H11      = 11'(H_VIDEO);
    localparam logic [10:0] V_LAST11 = 11'(V_VIDEO - 1);

    typedef enum logic [1:0] {IDLE, SERVE, MOVE, MISS} state_t;

    state_t            state_reg, state_next;
    logic [9:0]        x_reg, x_next;
    logic [9:0]        y_reg, y_next;
    logic              xdir_reg, xdir_next;
    logic              ydir_reg, ydir_next;
    logic              missed_reg, missed_next;
    logic              hit_reg, hit_next;
    logic              side_reg, side_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [DLY_W-1:0]  dly_reg, dly_next;
    logic [PSC_W-1:0]  psc_reg, psc_next;

    // 11-bit views so edge sums cannot wrap.
    logic [10:0] x11, y11, lp11, rp11;
    logic        l_overlap, r_overlap, l_hit, r_hit;
    logic        xd_step, yd_step;

    assign x11  = {1'b0, x_reg};
    assign y11  = {1'b0, y_reg};
    assign lp11 = {1'b0, l_pdl_ypos};
    assign rp11 = {1'b0, r_pdl_ypos};

    assign l_overlap = (y11 + SQ11 > lp11) && (y11 < lp11 + PH11);
    assign r_overlap = (y11 + SQ11 > rp11) && (y11 < rp11 + PH11);
    assign l_hit     = !xdir_reg && (x11 == L_HIT_X) && l_overlap;
    assign r_hit     = xdir_reg && (x11 + SQ11 == R_PDL11) && r_overlap;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            x_reg      <= X_CENTRE;
            y_reg      <= Y_CENTRE;
            xdir_reg   <= 1'b1;
            ydir_reg   <= 1'b1;
            missed_reg <= 1'b0;
            hit_reg    <= 1'b0;
            side_reg   <= 1'b0;
            tick_reg   <= '0;
            dly_reg    <= '0;
            psc_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            xdir_reg   <= xdir_next;
            ydir_reg   <= ydir_next;
            missed_reg <= missed_next;
            hit_reg    <= hit_next;
            side_reg   <= side_next;
            tick_reg   <= tick_next;
            dly_reg    <= dly_next;
            psc_reg    <= psc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        xdir_next   = xdir_reg;
        ydir_next   = ydir_reg;
        missed_next = 1'b0;
        hit_next    = 1'b0;
        side_next   = side_reg;
        tick_next   = tick_reg;
        dly_next    = dly_reg;
        psc_next    = psc_reg;
        xd_step     = xdir_reg;
        yd_step     = ydir_reg;

        if (mode_choice == 2'd0) begin
            state_next = IDLE;
            x_next     = X_CENTRE;
            y_next     = Y_CENTRE;
            tick_next  = '0;
            dly_next   = '0;
            psc_next   = '0;
        end else if (reset_game) begin
            state_next = SERVE;
            x_next     = X_CENTRE;
            y_next     = Y_CENTRE;
            xdir_next  = 1'b1;
            ydir_next  = 1'b1;
            tick_next  = '0;
            dly_next   = '0;
            psc_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = SERVE;
                    x_next     = X_CENTRE;
                    y_next     = Y_CENTRE;
                    tick_next  = '0;
                    dly_next   = '0;
                end
                SERVE: begin
                    x_next = X_CENTRE;
                    y_next = Y_CENTRE;
                    if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        if (dly_reg == DELAY_LAST) begin
                            state_next = MOVE;
                            dly_next   = '0;
                            psc_next   = '0;
                        end else begin
                            dly_next = dly_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                MOVE: begin
                    if (psc_reg == PSC_LAST) begin
                        psc_next = '0;
                        if (l_hit) begin
                            xd_step  = 1'b1;
                            hit_next = 1'b1;
                        end else if (r_hit) begin
                            xd_step  = 1'b0;
                            hit_next = 1'b1;
                        end
                        // A hit step can never be a miss step.
                        if (!l_hit && !r_hit && !xdir_reg && x11 == 11'd0) begin
                            state_next  = MISS;
                            missed_next = 1'b1;
                            side_next   = 1'b0;
                        end else if (!l_hit && !r_hit && xdir_reg && x11 + SQ11 == H11) begin
                            state_next  = MISS;
                            missed_next = 1'b1;
                            side_next   = 1'b1;
                        end else begin
                            if (!ydir_reg && y11 == 11'd0) begin
                                yd_step = 1'b1;
                            end else if (ydir_reg && y11 + SQ11 >= V_LAST11) begin
                                yd_step = 1'b0;
                            end
                            xdir_next = xd_step;
                            ydir_next = yd_step;
                            x_next    = xd_step ? x_reg + 10'd1 : x_reg - 10'd1;
                            y_next    = yd_step ? y_reg + 10'd1 : y_reg - 10'd1;
                        end
                    end else begin
                        psc_next = psc_reg + 1'b1;
                    end
                end
                MISS: begin
                    // Serve toward whoever conceded, vertical direction flipped.
                    state_next = SERVE;
                    x_next     = X_CENTRE;
                    y_next     = Y_CENTRE;
                    xdir_next  = side_reg;
                    ydir_next  = ~ydir_reg;
                    tick_next  = '0;
                    dly_next   = '0;
                    psc_next   = '0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign sq_xpos    = x_reg;
    assign sq_ypos    = y_reg;
    assign sq_xveldir = xdir_reg;
    assign sq_yveldir = ydir_reg;
    assign sq_missed  = missed_reg;
    assign miss_side  = side_reg;
    assign paddle_hit = hit_reg;

endmodule
